id_issue_queue: RTL and testbench
=================================

// Module: id_issue_queue
// PURPOSE
//  Parametrised decode->issue buffer; successor to the single-register ID/issue pipeline stage.
//  Holds up to Depth decoded scoreboard entries in a circular FIFO.
//  Presents the oldest IssueWidth entries to the issue stage, which may retire 0..IssueWidth per cycle.
//  Sits between decoder (+ macro sequencer) and issue_stage; absorbs issue back-pressure without starving fetch.
// PARAMETERS
//  CVA6Cfg             config_pkg::cva6_cfg_empty  core configuration
//  scoreboard_entry_t  logic  decoded-instruction payload type
//  Depth               4      FIFO entries; power of 2, >= IssueWidth, >= 2
//  IssueWidth          1      entries offered to issue per cycle (1 or 2)
// PORTS
//  clk_i                 in   1             subsystem clock
//  rst_ni                in   1             asynchronous reset, active low
//  flush_i               in   1             controller flush; drop all entries
//  dec_entry_i           in   sbe           decoded instruction
//  dec_orig_instr_i      in   32            raw instruction bits
//  dec_is_ctrl_flow_i    in   1             entry is a control-flow instruction
//  dec_valid_i           in   1             decoder output valid
//  dec_stall_i           in   1             macro sequencer: more micro-ops pending for this fetch entry
//  dec_ready_o           out  1             push accepted this cycle
//  fetch_entry_ready_o   out  1             frontend may advance: dec_ready_o & ~dec_stall_i
//  issue_entry_o         out  IW x sbe      entries, [0] = oldest
//  orig_instr_o          out  IW x 32       raw bits per slot
//  is_ctrl_flow_o        out  IW            control-flow flag per slot
//  issue_entry_valid_o   out  IW            slot k valid iff count > k
//  issue_instr_ack_i     in   IW            slot k consumed; must be thermometer (ack[k] -> ack[k-1])
//  occupancy_o           out  clog2(Depth+1)  current entry count
// BEHAVIOUR
//  Reset: pointers = 0, count = 0, all storage zeroed.
//  Reset: every output 0; fetch_entry_ready_o = 0 during reset.
//  n_pop = popcount(issue_instr_ack_i & issue_entry_valid_o).
//  Ack on an invalid slot is ignored.
//  Free check: dec_ready_o = (count < Depth) | (n_pop != 0), so a full queue accepts when the same cycle frees a slot.
//  Push = dec_valid_i & dec_ready_o.
//  Push writes at wr_ptr; wr_ptr += 1.
//  Pop: rd_ptr += n_pop.
//  count_n = count + push - n_pop.
//  Pointers are log2(Depth) bits and wrap modulo Depth.
//  Slot k reads storage[rd_ptr+k] (modulo Depth).
//  Latency: a push is visible on issue_* the next cycle (not with bypass; see CONFIGURATION).
//  dec_stall_i affects only fetch_entry_ready_o; the micro-op is still pushed, so a macro sequence enqueues one entry per cycle.
//  Flush: count_n = 0, rd_ptr = wr_ptr = 0, valids drop next cycle.
//  Flush: a push in the flush cycle is discarded; dec_ready_o is still 1, so the fetch entry is consumed.
//  Push + pop on an empty queue: push lands, count = 1.
//  Push + pop on a full queue: count stays Depth.
//  Simultaneous push and flush: flush wins.
//  Asynchronous reset mid-operation: all state cleared immediately, no residual valid.
//  SVA (non-synthesis):
//    - ack is thermometer-shaped.
//    - count <= Depth.
//    - no push when full without a pop.
// CONFIGURATION
//  ID_ISSUE_QUEUE_BYPASS_EN defined: when count == 0 and dec_valid_i, slot 0 shows dec_* combinationally (valid = 1).
//  If slot 0 is also acked that cycle, the entry is not written; zero-cycle latency.
//  ID_ISSUE_QUEUE_BYPASS_EN undefined: no bypass; minimum one-cycle latency; issue_* driven only from flops.
// STRUCTURE
//  Shared package (id_issue_queue_pkg):
//    - function popcount_therm(IW).
//    - localparams PtrW = $clog2(Depth) and CntW = $clog2(Depth+1).
//  scoreboard_entry_t is passed in as a parameter type and stays defined by the core.
//  One storage typedef is local: struct {sbe, orig_instr, is_ctrl_flow}.
//  Single module; no sub-module.
//  Storage is a flop array (small Depth); the read mux is combinational.
// TESTING
//  1. Reset, Depth=4, IW=1, push A -> valid_o[0]=1 next cycle with entry A; occupancy_o=1.
//  2. Fill 4 entries with no ack -> dec_ready_o=0; then ack + push in the same cycle -> ready=1, occupancy stays 4.
//  3. IW=2, 3 queued, ack=2'b11 -> next cycle slot0 = 3rd entry, valid_o=2'b01, rd_ptr wrapped correctly.
//  4. dec_stall_i=1 for 2 cycles with valid -> 2 entries pushed, fetch_entry_ready_o=0 both cycles, then 1.
//  5. flush_i with push and 3 queued -> occupancy_o=0 next cycle, valid_o=0, pushed entry absent.
//  6. BYPASS_EN, empty, push X + ack[0] -> issue_entry_o[0]=X same cycle, occupancy_o stays 0.
//     Without the macro: X appears next cycle.

Source files
------------

// File: rtl/id_issue_queue_pkg.sv
// rtl/id_issue_queue_pkg.sv - shared configuration type, width helpers and pop counter for the decode->issue queue
package id_issue_queue_pkg;

   typedef struct packed {
      int unsigned NrIssuePorts;
   } cfg_t;

   localparam cfg_t cva6_cfg_empty = '{NrIssuePorts: 2};

   // Pointer and count widths for a queue of the given depth.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic logic [1:0] popcount_therm(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

endpackage

// File: rtl/id_issue_queue_if.sv
// rtl/id_issue_queue_if.sv - decoder-side push and issue-side offer/ack signals of the issue queue
interface id_issue_queue_if #(
   parameter type         sbe_t      = logic,
   parameter int unsigned IssueWidth = 1
);
   sbe_t                  dec_entry_i;
   logic [31:0]           dec_orig_instr_i;
   logic                  dec_is_ctrl_flow_i;
   logic                  dec_valid_i;
   logic                  dec_stall_i;
   logic                  dec_ready_o;
   logic                  fetch_entry_ready_o;
   sbe_t                  issue_entry_o [IssueWidth];
   logic [31:0]           orig_instr_o  [IssueWidth];
   logic [IssueWidth-1:0] is_ctrl_flow_o;
   logic [IssueWidth-1:0] issue_entry_valid_o;
   logic [IssueWidth-1:0] issue_instr_ack_i;

   modport master (
      output dec_entry_i, dec_orig_instr_i, dec_is_ctrl_flow_i, dec_valid_i, dec_stall_i,
             issue_instr_ack_i,
      input  dec_ready_o, fetch_entry_ready_o, issue_entry_o, orig_instr_o, is_ctrl_flow_o,
             issue_entry_valid_o
   );

   modport slave (
      input  dec_entry_i, dec_orig_instr_i, dec_is_ctrl_flow_i, dec_valid_i, dec_stall_i,
             issue_instr_ack_i,
      output dec_ready_o, fetch_entry_ready_o, issue_entry_o, orig_instr_o, is_ctrl_flow_o,
             issue_entry_valid_o
   );
endinterface

// File: rtl/id_issue_queue.sv
// rtl/id_issue_queue.sv - circular decode->issue FIFO offering its oldest IssueWidth entries
// Optional zero-latency slot-0 bypass when empty: ID_ISSUE_QUEUE_BYPASS_EN
module id_issue_queue
   import id_issue_queue_pkg::*;
#(
   parameter cfg_t        CVA6Cfg            = cva6_cfg_empty,
   parameter type         scoreboard_entry_t = logic,
   parameter int unsigned Depth              = 4,
   parameter int unsigned IssueWidth         = 1,
   localparam int unsigned CntW              = cnt_width(Depth)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   id_issue_queue_if.slave q_if,
   output logic [CntW-1:0] occupancy_o
);

   localparam int unsigned PtrW = ptr_width(Depth);

   typedef struct packed {
      scoreboard_entry_t sbe;
      logic [31:0]       orig_instr;
      logic              is_ctrl_flow;
   } entry_t;

   entry_t                mem_q [Depth];
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]       count_q, count_d;
   entry_t                dec_ent;
   entry_t                slot_ent [IssueWidth];
   logic [IssueWidth-1:0] slot_valid, slot_cf, pop_mask;
   logic [1:0]            n_pop;
   logic                  dec_ready, push, bypass, store;

   assign dec_ent = '{sbe:          q_if.dec_entry_i,
                      orig_instr:   q_if.dec_orig_instr_i,
                      is_ctrl_flow: q_if.dec_is_ctrl_flow_i};

`ifdef ID_ISSUE_QUEUE_BYPASS_EN
   assign bypass = rst_ni & (count_q == '0) & q_if.dec_valid_i;
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      slot_valid = '0;
      slot_cf    = '0;
      for (int k = 0; k < IssueWidth; k++) begin
         slot_ent[k]   = mem_q[rd_ptr_q + PtrW'(k)];
         slot_valid[k] = count_q > CntW'(k);
      end
      if (bypass) begin
         slot_ent[0]   = dec_ent;
         slot_valid[0] = 1'b1;
      end
      for (int k = 0; k < IssueWidth; k++) begin
         slot_cf[k] = slot_ent[k].is_ctrl_flow;
      end
   end

   assign pop_mask  = q_if.issue_instr_ack_i & slot_valid;
   assign n_pop     = popcount_therm(2'(pop_mask));
   // A full queue still accepts when the same cycle retires an entry.
   assign dec_ready = rst_ni & ((count_q < CntW'(Depth)) | (n_pop != 2'd0));
   assign push      = q_if.dec_valid_i & dec_ready;
   // A bypassed entry consumed in the same cycle never needs a storage slot.
   assign store     = push & ~flush_i & ~(bypass & pop_mask[0]);

   always_comb begin
      rd_ptr_d = rd_ptr_q + PtrW'(n_pop);
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      count_d  = count_q + CntW'(push) - CntW'(n_pop);
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (store) begin
            mem_q[wr_ptr_q] <= dec_ent;
         end
      end
   end

   assign q_if.dec_ready_o         = dec_ready;
   assign q_if.fetch_entry_ready_o = dec_ready & ~q_if.dec_stall_i;
   assign q_if.issue_entry_valid_o = slot_valid;
   assign q_if.is_ctrl_flow_o      = slot_cf;
   assign occupancy_o              = count_q;

   for (genvar k = 0; k < IssueWidth; k++) begin : g_slot
      assign q_if.issue_entry_o[k] = slot_ent[k].sbe;
      assign q_if.orig_instr_o[k]  = slot_ent[k].orig_instr;
   end

`ifndef SYNTHESIS
   ack_thermometer: assert property (@(posedge clk_i) disable iff (!rst_ni)
      ((q_if.issue_instr_ack_i + IssueWidth'(1)) & q_if.issue_instr_ack_i) == '0);
   ack_within_ports: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $countones(q_if.issue_instr_ack_i) <= CVA6Cfg.NrIssuePorts);
   count_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
      count_q <= CntW'(Depth));
   no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      push |-> ((count_q < CntW'(Depth)) || (n_pop != 2'd0)));
`endif

endmodule

// File: tb/tb_id_issue_queue.sv
// tb/tb_id_issue_queue.sv - directed and randomized checks of id_issue_queue against a queue model
module tb_id_issue_queue;
   typedef logic [15:0] sbe_t;
   typedef struct packed { sbe_t sbe; logic [31:0] instr; logic cf; } item_t;

`ifdef ID_ISSUE_QUEUE_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   logic       clk = 1'b0, rst_n = 1'b0, flush1 = 1'b0, flush2 = 1'b0;
   logic [2:0] occ1, occ2;
   int         n_checks = 0, n_fail = 0;

   id_issue_queue_if #(.sbe_t(sbe_t), .IssueWidth(1)) if1 ();
   id_issue_queue_if #(.sbe_t(sbe_t), .IssueWidth(2)) if2 ();

   id_issue_queue #(.scoreboard_entry_t(sbe_t), .Depth(4), .IssueWidth(1)) u1 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush1), .q_if(if1.slave), .occupancy_o(occ1));
   id_issue_queue #(.scoreboard_entry_t(sbe_t), .Depth(4), .IssueWidth(2)) u2 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush2), .q_if(if2.slave), .occupancy_o(occ2));

   always #5 clk = ~clk;

   task automatic drive1(input logic v, input sbe_t e, input logic ack, input logic stall);
      if1.dec_valid_i = v; if1.dec_entry_i = e; if1.dec_orig_instr_i = {16'hA5A5, e};
      if1.dec_is_ctrl_flow_i = e[0]; if1.dec_stall_i = stall; if1.issue_instr_ack_i = ack;
   endtask

   task automatic drive2(input logic v, input sbe_t e, input logic [1:0] ack);
      if2.dec_valid_i = v; if2.dec_entry_i = e; if2.dec_orig_instr_i = {16'h5A5A, e};
      if2.dec_is_ctrl_flow_i = e[0]; if2.dec_stall_i = 1'b0; if2.issue_instr_ack_i = ack;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      drive1(1'b1, 16'h1111, 1'b0, 1'b0);
      drive2(1'b1, 16'h2222, 2'b00);
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (if1.issue_entry_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid1 got %b want 0", if1.issue_entry_valid_o); end
      n_checks++; if (if1.dec_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready1 got %b want 0", if1.dec_ready_o); end
      n_checks++; if (if1.fetch_entry_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_ready1 got %b want 0", if1.fetch_entry_ready_o); end
      n_checks++; if (if1.issue_entry_o[0] !== 16'h0) begin n_fail++; $display("FAIL reset_entry1 got %h want 0", if1.issue_entry_o[0]); end
      n_checks++; if (occ1 !== 3'd0) begin n_fail++; $display("FAIL reset_occ1 got %0d want 0", occ1); end
      n_checks++; if (if2.issue_entry_valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_valid2 got %b want 00", if2.issue_entry_valid_o); end
      n_checks++; if (occ2 !== 3'd0) begin n_fail++; $display("FAIL reset_occ2 got %0d want 0", occ2); end
      drive1(1'b0, 16'h0, 1'b0, 1'b0);
      drive2(1'b0, 16'h0, 2'b00);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_push_latency();
      drive1(1'b1, 16'h1A1A, 1'b0, 1'b0); #1;
`ifdef ID_ISSUE_QUEUE_BYPASS_EN
      n_checks++; if (if1.issue_entry_valid_o !== 1'b1 || if1.issue_entry_o[0] !== 16'h1A1A) begin n_fail++; $display("FAIL latency_bypass got v=%b e=%h want v=1 e=1a1a", if1.issue_entry_valid_o, if1.issue_entry_o[0]); end
`else
      n_checks++; if (if1.issue_entry_valid_o !== 1'b0) begin n_fail++; $display("FAIL latency_same_cycle got %b want 0", if1.issue_entry_valid_o); end
`endif
      tick(); drive1(1'b0, 16'h0, 1'b0, 1'b0); #1;
      n_checks++; if (if1.issue_entry_valid_o !== 1'b1) begin n_fail++; $display("FAIL latency_valid got %b want 1", if1.issue_entry_valid_o); end
      n_checks++; if (if1.issue_entry_o[0] !== 16'h1A1A || if1.orig_instr_o[0] !== 32'hA5A51A1A) begin n_fail++; $display("FAIL latency_entry got %h/%h want 1a1a/a5a51a1a", if1.issue_entry_o[0], if1.orig_instr_o[0]); end
      n_checks++; if (occ1 !== 3'd1) begin n_fail++; $display("FAIL latency_occ got %0d want 1", occ1); end
      drive1(1'b0, 16'h0, 1'b1, 1'b0); tick(); drive1(1'b0, 16'h0, 1'b0, 1'b0); #1;
      n_checks++; if (occ1 !== 3'd0) begin n_fail++; $display("FAIL latency_drain got %0d want 0", occ1); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         drive1(1'b1, 16'h2000 + sbe_t'(i), 1'b0, 1'b0); tick();
      end
      drive1(1'b1, 16'h2004, 1'b0, 1'b0); #1;
      n_checks++; if (if1.dec_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", if1.dec_ready_o); end
      n_checks++; if (occ1 !== 3'd4) begin n_fail++; $display("FAIL full_occ got %0d want 4", occ1); end
      tick(); drive1(1'b1, 16'h2005, 1'b1, 1'b0); #1;
      n_checks++; if (if1.dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_ack_ready got %b want 1", if1.dec_ready_o); end
      tick(); drive1(1'b0, 16'h0, 1'b0, 1'b0); #1;
      n_checks++; if (occ1 !== 3'd4) begin n_fail++; $display("FAIL full_ack_occ got %0d want 4", occ1); end
      n_checks++; if (if1.issue_entry_o[0] !== 16'h2001) begin n_fail++; $display("FAIL full_head got %h want 2001", if1.issue_entry_o[0]); end
      drive1(1'b0, 16'h0, 1'b1, 1'b0); repeat (4) tick(); drive1(1'b0, 16'h0, 1'b0, 1'b0); #1;
      n_checks++; if (occ1 !== 3'd0) begin n_fail++; $display("FAIL full_drain got %0d want 0", occ1); end
   endtask

   task automatic test_wrap();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 3; i++) begin
            drive2(1'b1, 16'h3000 + sbe_t'(r * 16 + i), 2'b00); tick();
         end
         drive2(1'b0, 16'h0, 2'b11); #1;
         n_checks++; if (if2.issue_entry_valid_o !== 2'b11 || if2.issue_entry_o[1] !== 16'h3001 + sbe_t'(r * 16)) begin n_fail++; $display("FAIL wrap_pair r%0d got v=%b e1=%h", r, if2.issue_entry_valid_o, if2.issue_entry_o[1]); end
         tick(); drive2(1'b0, 16'h0, 2'b00); #1;
         n_checks++; if (if2.issue_entry_valid_o !== 2'b01) begin n_fail++; $display("FAIL wrap_valid r%0d got %b want 01", r, if2.issue_entry_valid_o); end
         n_checks++; if (if2.issue_entry_o[0] !== 16'h3002 + sbe_t'(r * 16)) begin n_fail++; $display("FAIL wrap_head r%0d got %h want %h", r, if2.issue_entry_o[0], 16'h3002 + r * 16); end
         drive2(1'b0, 16'h0, 2'b01); tick(); drive2(1'b0, 16'h0, 2'b00);
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 2; i++) begin
         drive1(1'b1, 16'h4000 + sbe_t'(i), 1'b0, 1'b1); #1;
         n_checks++; if (if1.fetch_entry_ready_o !== 1'b0 || if1.dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_%0d got fetch=%b ready=%b want 0/1", i, if1.fetch_entry_ready_o, if1.dec_ready_o); end
         tick();
      end
      drive1(1'b0, 16'h0, 1'b0, 1'b0); #1;
      n_checks++; if (if1.fetch_entry_ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_release got %b want 1", if1.fetch_entry_ready_o); end
      n_checks++; if (occ1 !== 3'd2 || if1.issue_entry_o[0] !== 16'h4000) begin n_fail++; $display("FAIL stall_occ got %0d/%h want 2/4000", occ1, if1.issue_entry_o[0]); end
      drive1(1'b0, 16'h0, 1'b1, 1'b0); repeat (2) tick(); drive1(1'b0, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive2(1'b1, 16'h5000 + sbe_t'(i), 2'b00); tick();
      end
      drive2(1'b1, 16'h5FFF, 2'b00); flush2 = 1'b1; #1;
      n_checks++; if (if2.dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", if2.dec_ready_o); end
      tick(); flush2 = 1'b0; drive2(1'b0, 16'h0, 2'b00); #1;
      n_checks++; if (occ2 !== 3'd0 || if2.issue_entry_valid_o !== 2'b00) begin n_fail++; $display("FAIL flush_empty got occ=%0d v=%b want 0/00", occ2, if2.issue_entry_valid_o); end
      drive2(1'b1, 16'h5AAA, 2'b00); tick(); drive2(1'b0, 16'h0, 2'b00); #1;
      n_checks++; if (occ2 !== 3'd1 || if2.issue_entry_o[0] !== 16'h5AAA) begin n_fail++; $display("FAIL flush_after got occ=%0d e=%h want 1/5aaa", occ2, if2.issue_entry_o[0]); end
      drive2(1'b0, 16'h0, 2'b01); tick(); drive2(1'b0, 16'h0, 2'b00);
   endtask

   task automatic test_bypass();
      drive1(1'b1, 16'h6666, 1'b1, 1'b0); #1;
`ifdef ID_ISSUE_QUEUE_BYPASS_EN
      n_checks++; if (if1.issue_entry_valid_o !== 1'b1 || if1.issue_entry_o[0] !== 16'h6666) begin n_fail++; $display("FAIL bypass_same got v=%b e=%h want 1/6666", if1.issue_entry_valid_o, if1.issue_entry_o[0]); end
      tick(); drive1(1'b0, 16'h0, 1'b0, 1'b0); #1;
      n_checks++; if (occ1 !== 3'd0 || if1.issue_entry_valid_o !== 1'b0) begin n_fail++; $display("FAIL bypass_consumed got occ=%0d v=%b want 0/0", occ1, if1.issue_entry_valid_o); end
`else
      n_checks++; if (if1.issue_entry_valid_o !== 1'b0) begin n_fail++; $display("FAIL nobypass_same got %b want 0", if1.issue_entry_valid_o); end
      tick(); drive1(1'b0, 16'h0, 1'b0, 1'b0); #1;
      n_checks++; if (occ1 !== 3'd1 || if1.issue_entry_o[0] !== 16'h6666) begin n_fail++; $display("FAIL nobypass_next got occ=%0d e=%h want 1/6666", occ1, if1.issue_entry_o[0]); end
      drive1(1'b0, 16'h0, 1'b1, 1'b0); tick(); drive1(1'b0, 16'h0, 1'b0, 1'b0);
`endif
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 2; i++) begin
         drive2(1'b1, 16'h7000 + sbe_t'(i), 2'b00); tick();
      end
      drive2(1'b0, 16'h0, 2'b00);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (if2.issue_entry_valid_o !== 2'b00 || occ2 !== 3'd0) begin n_fail++; $display("FAIL async_reset got v=%b occ=%0d want 00/0", if2.issue_entry_valid_o, occ2); end
      @(posedge clk); #1 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_random(input int cycles);
      item_t      mq[$];
      item_t      it, exp;
      logic       dv, fl, byp, rdy;
      logic [1:0] ack, ev;
      int         n;
      for (int c = 0; c < cycles; c++) begin
         dv = ($urandom_range(3) != 0);
         fl = ($urandom_range(24) == 0);
         case ($urandom_range(2))
            0: ack = 2'b00;
            1: ack = 2'b01;
            default: ack = 2'b11;
         endcase
         it.sbe = sbe_t'($urandom); it.instr = $urandom; it.cf = 1'($urandom_range(1));
         if2.dec_valid_i = dv; if2.dec_entry_i = it.sbe; if2.dec_orig_instr_i = it.instr;
         if2.dec_is_ctrl_flow_i = it.cf; if2.dec_stall_i = 1'($urandom_range(1));
         if2.issue_instr_ack_i = ack; flush2 = fl;
         #1;
         byp   = Bypass && mq.size() == 0 && dv;
         ev[0] = mq.size() > 0 || byp;
         ev[1] = mq.size() > 1;
         n     = int'(ack[0] & ev[0]) + int'(ack[1] & ev[1]);
         rdy   = mq.size() < 4 || n > 0;
         n_checks++; if (if2.issue_entry_valid_o !== ev) begin n_fail++; $display("FAIL rnd_valid c%0d got %b want %b", c, if2.issue_entry_valid_o, ev); end
         n_checks++; if (if2.dec_ready_o !== rdy || if2.fetch_entry_ready_o !== (rdy & ~if2.dec_stall_i)) begin n_fail++; $display("FAIL rnd_ready c%0d got %b/%b want %b", c, if2.dec_ready_o, if2.fetch_entry_ready_o, rdy); end
         n_checks++; if (occ2 !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_occ c%0d got %0d want %0d", c, occ2, mq.size()); end
         for (int k = 0; k < 2; k++) begin
            if (ev[k]) begin
               exp = (k == 0 && byp) ? it : mq[k];
               n_checks++;
               if ({if2.issue_entry_o[k], if2.orig_instr_o[k], if2.is_ctrl_flow_o[k]} !== exp) begin
                  n_fail++; $display("FAIL rnd_slot%0d c%0d got %h want %h", k, c, {if2.issue_entry_o[k], if2.orig_instr_o[k], if2.is_ctrl_flow_o[k]}, exp);
               end
            end
         end
         @(posedge clk); #1;
         if (fl) mq.delete();
         else if (byp) begin
            if (!ack[0]) mq.push_back(it);
         end else begin
            repeat (n) void'(mq.pop_front());
            if (dv && rdy) mq.push_back(it);
         end
      end
      drive2(1'b0, 16'h0, 2'b00); flush2 = 1'b1; tick(); flush2 = 1'b0;
   endtask

   initial begin
      drive1(1'b0, 16'h0, 1'b0, 1'b0);
      drive2(1'b0, 16'h0, 2'b00);
      test_reset();
      test_push_latency();
      test_full();
      test_wrap();
      test_stall();
      test_flush();
      test_bypass();
      test_async_reset();
      test_random(400);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
